onehot_walker: RTL and testbench

//   Parametrised one-hot walking sequencer: idles at all-zero, then walks a

---
 rtl/onehot_walker.sv | 146 ++++++++++++++
 tb/tb_onehot_walker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_walker.sv
// onehot_walker
//   Parametrised one-hot walking sequencer. Idles at all-zero for IDLE_CYCLES
//   enabled cycles, then walks a single set bit across WIDTH bits in the
//   direction latched at walk entry. With WRAP=1 the walk repeats; with WRAP=0
//   it parks on the last bit until clear/reset. Used as a phase-select strobe.
//
//   Parameters
//     WIDTH        number of state bits (>=2)
//     IDLE_CYCLES  enabled cycles at all-zero before a walk starts (0..255)
//     WRAP         1: repeat after the last bit, 0: hold at the last bit
//   Ports
//     clk      clock, all logic on posedge
//     rst      synchronous reset, active low
//     i_en     advance enable; state frozen when low
//     i_clr    synchronous clear to idle, takes priority over i_en
//     i_dir    0: bit0 -> bit WIDTH-1, 1: bit WIDTH-1 -> bit0 (sampled on entry)
//     o_state  one-hot or all-zero sequencer state
//     o_pos    index of the set bit, 0 when idle
//     o_busy   o_state != 0
//     o_wrap   one-cycle pulse: the last bit was left on this edge
//     o_done   WRAP=0 only: holding at the last bit
module onehot_walker #(
  parameter int WIDTH       = 3,
  parameter int IDLE_CYCLES = 1,
  parameter bit WRAP        = 1'b1,
  localparam int PW         = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_state,
  output logic [PW-1:0]    o_pos,
  output logic             o_busy,
  output logic             o_wrap,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] LSB_BIT   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_BIT   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [7:0]       IDLE_LAST = (IDLE_CYCLES == 0) ? 8'd0 : 8'(IDLE_CYCLES - 1);

  function automatic logic [PW-1:0] enc(input logic [WIDTH-1:0] s);
    enc = '0;
    for (int i = 0; i < WIDTH; i++)
      if (s[i]) enc = PW'(i);
  endfunction

  logic [WIDTH-1:0] r_state;
  logic [PW-1:0]    r_pos;
  logic             r_busy, r_wrap, r_done, r_dir_q;
  logic [7:0]       r_idle_cnt;

  logic [WIDTH-1:0] w_first, w_last, w_state_n, w_last_n;
  logic             w_at_last, w_dir_n, w_wrap_n, w_done_n;
  logic [7:0]       w_cnt_n;

  // Entry bit follows the live dir; the end of the walk follows the latched one.
  assign w_first   = i_dir ? MSB_BIT : LSB_BIT;
  assign w_last    = r_dir_q ? LSB_BIT : MSB_BIT;
  assign w_at_last = (r_state == w_last);

  always_comb begin
    w_state_n = r_state;
    w_dir_n   = r_dir_q;
    w_cnt_n   = r_idle_cnt;
    w_wrap_n  = 1'b0;
    if (i_en) begin
      if (r_state == '0) begin
        if (IDLE_CYCLES == 0 || r_idle_cnt == IDLE_LAST) begin
          w_state_n = w_first;
          w_dir_n   = i_dir;
          w_cnt_n   = 8'd0;
        end else begin
          w_cnt_n = r_idle_cnt + 8'd1;
        end
      end else if (w_at_last) begin
        if (WRAP) begin
          w_wrap_n = 1'b1;
          // With no idle dwell the walker is a pure ring: re-enter directly.
          if (IDLE_CYCLES == 0) begin
            w_state_n = w_first;
            w_dir_n   = i_dir;
          end else begin
            w_state_n = '0;
          end
        end
      end else begin
        w_state_n = r_dir_q ? (r_state >> 1) : (r_state << 1);
      end
    end
    // done is derived from the next state so it rises together with arrival.
    w_last_n = w_dir_n ? LSB_BIT : MSB_BIT;
    w_done_n = !WRAP && (w_state_n == w_last_n);
  end

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_state    <= '0;
      r_pos      <= '0;
      r_busy     <= 1'b0;
      r_wrap     <= 1'b0;
      r_done     <= 1'b0;
      r_dir_q    <= 1'b0;
      r_idle_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_n;
      r_pos      <= enc(w_state_n);
      r_busy     <= (w_state_n != '0);
      r_wrap     <= w_wrap_n;
      r_done     <= w_done_n;
      r_dir_q    <= w_dir_n;
      r_idle_cnt <= w_cnt_n;
    end
  end

  assign o_state = r_state;
  assign o_pos   = r_pos;
  assign o_busy  = r_busy;
  assign o_wrap  = r_wrap;
  assign o_done  = r_done;

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_state));
  a_busy:   assert property (@(posedge clk) disable iff (!rst) r_busy == (r_state != '0));
  a_pos:    assert property (@(posedge clk) disable iff (!rst) r_pos == enc(r_state));
  a_wrap:   assert property (@(posedge clk) disable iff (!rst)
                             r_wrap |-> ($past(w_at_last) && $past(i_en)));

  generate
    if (!WRAP) begin : g_hold
      a_done_hold: assert property (@(posedge clk) disable iff (!rst)
                                    (r_done && !i_clr) |=> r_done);
    end
    for (genvar b = 0; b < WIDTH; b++) begin : g_cov
      c_bit: cover property (@(posedge clk) disable iff (!rst) r_state == LSB_BIT << b);
    end
  endgenerate

  c_wrap:     cover property (@(posedge clk) disable iff (!rst) r_wrap);
  c_dir1_end: cover property (@(posedge clk) disable iff (!rst)
                              r_dir_q && (r_state == LSB_BIT) && i_en);
`endif

endmodule

// File: tb/tb_onehot_walker.sv
module tb_onehot_walker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clr, dir;

  logic [2:0] st0; logic [1:0] ps0; logic bs0, wr0, dn0;
  logic [7:0] st1; logic [2:0] ps1; logic bs1, wr1, dn1;
  logic [3:0] st2; logic [1:0] ps2; logic bs2, wr2, dn2;
  logic [3:0] st3; logic [1:0] ps3; logic bs3, wr3, dn3;
  logic [4:0] st4; logic [2:0] ps4; logic bs4, wr4, dn4;

  onehot_walker #(.WIDTH(3), .IDLE_CYCLES(1), .WRAP(1'b1)) u0 (.clk(clk), .rst(rst), .i_en(en),
    .i_clr(clr), .i_dir(dir), .o_state(st0), .o_pos(ps0), .o_busy(bs0), .o_wrap(wr0), .o_done(dn0));
  onehot_walker #(.WIDTH(8), .IDLE_CYCLES(1), .WRAP(1'b1)) u1 (.clk(clk), .rst(rst), .i_en(en),
    .i_clr(clr), .i_dir(dir), .o_state(st1), .o_pos(ps1), .o_busy(bs1), .o_wrap(wr1), .o_done(dn1));
  onehot_walker #(.WIDTH(4), .IDLE_CYCLES(3), .WRAP(1'b1)) u2 (.clk(clk), .rst(rst), .i_en(en),
    .i_clr(clr), .i_dir(dir), .o_state(st2), .o_pos(ps2), .o_busy(bs2), .o_wrap(wr2), .o_done(dn2));
  onehot_walker #(.WIDTH(4), .IDLE_CYCLES(1), .WRAP(1'b0)) u3 (.clk(clk), .rst(rst), .i_en(en),
    .i_clr(clr), .i_dir(dir), .o_state(st3), .o_pos(ps3), .o_busy(bs3), .o_wrap(wr3), .o_done(dn3));
  onehot_walker #(.WIDTH(5), .IDLE_CYCLES(0), .WRAP(1'b1)) u4 (.clk(clk), .rst(rst), .i_en(en),
    .i_clr(clr), .i_dir(dir), .o_state(st4), .o_pos(ps4), .o_busy(bs4), .o_wrap(wr4), .o_done(dn4));

  // Reference model: walker position as an integer index (-1 = idle).
  int MW[5] = '{3, 8, 4, 4, 5};
  int MI[5] = '{1, 1, 3, 1, 0};
  int MR[5] = '{1, 1, 1, 0, 1};
  int m_idx[5], m_cnt[5];
  bit m_d[5], m_wr[5], m_dn[5];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit e, input bit d);
    for (int k = 0; k < 5; k++) begin
      if (!r || c) begin
        m_idx[k] = -1; m_cnt[k] = 0; m_d[k] = 0; m_wr[k] = 0; m_dn[k] = 0;
      end else begin
        m_wr[k] = 0;
        if (e) begin
          int last;
          last = m_d[k] ? 0 : MW[k] - 1;
          if (m_idx[k] < 0) begin
            if (MI[k] == 0 || m_cnt[k] == MI[k] - 1) begin
              m_d[k] = d; m_idx[k] = d ? MW[k] - 1 : 0; m_cnt[k] = 0;
            end else m_cnt[k]++;
          end else if (m_idx[k] == last) begin
            if (MR[k] == 1) begin
              m_wr[k] = 1;
              if (MI[k] == 0) begin m_d[k] = d; m_idx[k] = d ? MW[k] - 1 : 0; end
              else m_idx[k] = -1;
            end
          end else m_idx[k] += m_d[k] ? -1 : 1;
          last = m_d[k] ? 0 : MW[k] - 1;
          m_dn[k] = (MR[k] == 0) && (m_idx[k] == last);
        end
      end
    end
  endtask

  task automatic get_act(input int k, output logic [7:0] s, output logic [2:0] p,
                         output logic b, output logic w, output logic dn);
    case (k)
      0: begin s = {5'd0, st0}; p = {1'b0, ps0}; b = bs0; w = wr0; dn = dn0; end
      1: begin s = st1;         p = ps1;         b = bs1; w = wr1; dn = dn1; end
      2: begin s = {4'd0, st2}; p = {1'b0, ps2}; b = bs2; w = wr2; dn = dn2; end
      3: begin s = {4'd0, st3}; p = {1'b0, ps3}; b = bs3; w = wr3; dn = dn3; end
      default: begin s = {3'd0, st4}; p = ps4; b = bs4; w = wr4; dn = dn4; end
    endcase
  endtask

  task automatic check_all();
    for (int k = 0; k < 5; k++) begin
      logic [7:0] s, es; logic [2:0] p, ep; logic b, w, dn;
      get_act(k, s, p, b, w, dn);
      es = (m_idx[k] < 0) ? 8'd0 : 8'(1 << m_idx[k]);
      ep = (m_idx[k] < 0) ? 3'd0 : 3'(m_idx[k]);
      chk($sformatf("model_u%0d {state,pos,busy,wrap,done}", k),
          {17'd0, s, p, b, w, dn}, {17'd0, es, ep, m_idx[k] >= 0, m_wr[k], m_dn[k]});
    end
  endtask

  task automatic tick(input bit r, input bit c, input bit e, input bit d);
    rst = r; clr = c; en = e; dir = d;
    @(posedge clk);
    model_step(r, c, e, d);
    #1;
    check_all();
    @(negedge clk);
  endtask

  typedef struct {
    bit         en, clr, dir;
    logic [2:0] st;
    bit         wr;
  } vec_t;
  vec_t tbl[13];

  initial begin
    rst = 1'b0; clr = 1'b0; en = 1'b0; dir = 1'b0;
    for (int k = 0; k < 5; k++) begin
      m_idx[k] = -1; m_cnt[k] = 0; m_d[k] = 0; m_wr[k] = 0; m_dn[k] = 0;
    end

    tbl[0]  = '{1, 0, 0, 3'b001, 0};
    tbl[1]  = '{1, 0, 0, 3'b010, 0};
    tbl[2]  = '{1, 0, 0, 3'b100, 0};
    tbl[3]  = '{1, 0, 0, 3'b000, 1};
    tbl[4]  = '{0, 0, 0, 3'b000, 0};
    tbl[5]  = '{1, 0, 1, 3'b100, 0};
    tbl[6]  = '{1, 0, 0, 3'b010, 0};
    tbl[7]  = '{0, 0, 0, 3'b010, 0};
    tbl[8]  = '{1, 1, 0, 3'b000, 0};
    tbl[9]  = '{1, 0, 0, 3'b001, 0};
    tbl[10] = '{1, 0, 0, 3'b010, 0};
    tbl[11] = '{1, 0, 0, 3'b100, 0};
    tbl[12] = '{1, 1, 0, 3'b000, 0};

    tick(0, 0, 1, 0);
    tick(0, 0, 1, 1);
    chk("reset_outputs", {st1, st0, st2, st3, st4, bs1, wr1, dn3, ps1}, 32'd0);

    // WIDTH=3 basic walk, dir latch, clr priority
    for (int i = 0; i < 13; i++) begin
      tick(1, tbl[i].clr, tbl[i].en, tbl[i].dir);
      chk($sformatf("vec%0d state/wrap", i), {28'd0, st0, wr0}, {28'd0, tbl[i].st, tbl[i].wr});
    end

    // WIDTH=8 dir=1, advances only on en
    tick(1, 1, 0, 0);
    tick(1, 0, 1, 1);
    chk("w8_first_msb", {24'd0, st1}, 32'h80);
    tick(1, 0, 0, 1);
    chk("w8_hold_en0", {24'd0, st1}, 32'h80);
    tick(1, 0, 1, 1);
    chk("w8_step", {24'd0, st1}, 32'h40);

    // WIDTH=4 IDLE=3 dwell, mid-walk dir flip ignored
    tick(1, 1, 0, 0);
    tick(1, 0, 1, 0);
    tick(1, 0, 1, 0);
    chk("idle3_dwell", {28'd0, st2}, 32'h0);
    tick(1, 0, 1, 0);
    chk("idle3_entry", {28'd0, st2}, 32'h1);
    tick(1, 0, 1, 0);
    tick(1, 0, 1, 1);
    chk("idle3_dir_ignored", {28'd0, st2}, 32'h4);

    // WRAP=0 hold with done, then clr
    tick(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 0);
    chk("hold_arrive", {27'd0, st3, dn3}, {27'd0, 4'b1000, 1'b1});
    for (int i = 0; i < 10; i++) tick(1, 0, 1, 0);
    chk("hold_10", {26'd0, st3, dn3, wr3}, {26'd0, 4'b1000, 1'b1, 1'b0});
    tick(1, 1, 1, 0);
    chk("hold_clr", {27'd0, st3, dn3}, 32'd0);

    // WIDTH=5 IDLE=0 pure ring, clr+en at last bit
    for (int i = 0; i < 5; i++) tick(1, 0, 1, 0);
    chk("ring_last", {27'd0, st4}, 32'h10);
    tick(1, 0, 1, 0);
    chk("ring_wrap", {26'd0, st4, wr4}, {26'd0, 5'b00001, 1'b1});
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 0);
    tick(1, 1, 1, 0);
    chk("ring_clr_nowrap", {26'd0, st4, wr4}, 32'd0);

    // rst mid-walk with en high
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0);
    chk("pre_rst", {28'd0, st3}, 32'h4);
    tick(0, 0, 1, 0);
    chk("rst_midwalk", {st1, st0, st2, st3, bs3, dn3, ps3, wr0, st4[1:0]}, 32'd0);
    tick(1, 0, 1, 0);
    chk("after_rst", {28'd0, st3}, 32'h1);

    // randomized run against the model
    for (int i = 0; i < 600; i++) begin
      bit r, c, e, d;
      r = ($urandom_range(63) != 0);
      c = ($urandom_range(31) == 0);
      e = ($urandom_range(9) < 7);
      d = 1'($urandom_range(1));
      tick(r, c, e, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
